// File: rtl/seg_scan_decoder.sv
// Receiver for the multiplexed 6-digit 7-segment scan bus: settles each digit dwell,
// decodes the segment pattern to hex and reassembles a 24-bit frame with dp and error flags.
module seg_scan_decoder #(
   parameter int unsigned SETTLE_CYC  = 16,
   parameter int unsigned TIMEOUT_CYC = 200_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  sel,
   input  logic [7:0]  seg,
   output logic [23:0] data_out,
   output logic [5:0]  dp_out,
   output logic        data_valid,
   output logic        code_err,
   output logic        seq_err
);

   localparam int unsigned STAB_W = (SETTLE_CYC  > 2) ? $clog2(SETTLE_CYC)  : 1;
   localparam int unsigned TO_W   = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

   typedef enum logic [1:0] {ST_WAIT_START, ST_COLLECT, ST_DONE} state_t;

   state_t              r_state, w_state_nxt;
   logic [2:0]          r_sel_m, r_sel_s;
   logic [7:0]          r_seg_m, r_seg_s;
   logic [10:0]         r_prev;
   logic [STAB_W-1:0]   r_stab;
   logic [TO_W-1:0]     r_to;
   logic [2:0]          r_exp, w_exp_nxt;
   logic [23:0]         r_sh_data, r_data;
   logic [5:0]          r_sh_dp, r_dp;
   logic                r_sh_err, r_err, r_dv, r_seq;

   logic [10:0]         w_samp;
   logic                w_same, w_commit, w_timeout;
   logic [2:0]          w_c_sel;
   logic [7:0]          w_c_seg;
   logic [3:0]          w_nib;
   logic                w_bad, w_store, w_clr_err, w_seq_pulse, w_load;

   assign w_samp  = {r_sel_s, r_seg_s};
   assign w_same  = (w_samp == r_prev);
   assign w_c_sel = w_samp[10:8];
   assign w_c_seg = w_samp[7:0];
   // Commit on the sample that takes the counter to SETTLE_CYC-1; saturation keeps it to once per dwell.
   assign w_commit  = w_same && (r_stab == STAB_W'(SETTLE_CYC - 2)) && (w_c_sel < 3'd6);
   assign w_timeout = (r_state == ST_COLLECT) && (r_to == TO_W'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sel_m <= '0;
         r_sel_s <= '0;
         r_seg_m <= '0;
         r_seg_s <= '0;
         r_prev  <= '0;
         r_stab  <= '0;
      end else begin
         r_sel_m <= sel;
         r_sel_s <= r_sel_m;
         r_seg_m <= seg;
         r_seg_s <= r_seg_m;
         r_prev  <= w_samp;
         if (!w_same)
            r_stab <= '0;
         else if (r_stab != STAB_W'(SETTLE_CYC - 1))
            r_stab <= r_stab + 1'b1;
      end
   end

   always_comb begin
      w_nib = '0;
      w_bad = 1'b0;
      case (w_c_seg[6:0])
         7'h40: w_nib = 4'h0;
         7'h79: w_nib = 4'h1;
         7'h24: w_nib = 4'h2;
         7'h30: w_nib = 4'h3;
         7'h19: w_nib = 4'h4;
         7'h12: w_nib = 4'h5;
         7'h02: w_nib = 4'h6;
         7'h78: w_nib = 4'h7;
         7'h00: w_nib = 4'h8;
         7'h10: w_nib = 4'h9;
         7'h08: w_nib = 4'hA;
         7'h03: w_nib = 4'hB;
         7'h46: w_nib = 4'hC;
         7'h21: w_nib = 4'hD;
         7'h06: w_nib = 4'hE;
         7'h0E: w_nib = 4'hF;
         default: w_bad = 1'b1;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_WAIT_START;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_exp_nxt   = r_exp;
      w_store     = 1'b0;
      w_clr_err   = 1'b0;
      w_seq_pulse = 1'b0;
      w_load      = 1'b0;
      case (r_state)
         ST_WAIT_START: begin
            if (w_commit && (w_c_sel == 3'd0)) begin
               w_store     = 1'b1;
               w_clr_err   = 1'b1;
               w_exp_nxt   = 3'd1;
               w_state_nxt = ST_COLLECT;
            end
         end
         ST_COLLECT: begin
            if (w_commit) begin
               if (w_c_sel == r_exp) begin
                  w_store   = 1'b1;
                  w_exp_nxt = r_exp + 3'd1;
                  if (w_c_sel == 3'd5) w_state_nxt = ST_DONE;
               end else if (w_c_sel == 3'd0) begin
                  w_store     = 1'b1;
                  w_clr_err   = 1'b1;
                  w_exp_nxt   = 3'd1;
                  w_seq_pulse = 1'b1;
               end else begin
                  w_seq_pulse = 1'b1;
                  w_state_nxt = ST_WAIT_START;
               end
            end else if (w_timeout) begin
               w_seq_pulse = 1'b1;
               w_state_nxt = ST_WAIT_START;
            end
         end
         ST_DONE: begin
            w_load      = 1'b1;
            w_state_nxt = ST_WAIT_START;
         end
         default: w_state_nxt = ST_WAIT_START;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_to      <= '0;
         r_exp     <= '0;
         r_sh_data <= '0;
         r_sh_dp   <= '0;
         r_sh_err  <= 1'b0;
         r_data    <= '0;
         r_dp      <= '0;
         r_err     <= 1'b0;
         r_dv      <= 1'b0;
         r_seq     <= 1'b0;
      end else begin
         r_to  <= ((r_state != ST_COLLECT) || w_commit) ? '0 : r_to + 1'b1;
         r_exp <= w_exp_nxt;
         r_dv  <= w_load;
         r_seq <= w_seq_pulse;
         if (w_store) begin
            for (int unsigned i = 0; i < 6; i++) begin
               if (w_c_sel == 3'(i)) begin
                  r_sh_data[(5-i)*4 +: 4] <= w_nib;
                  r_sh_dp[5-i]            <= ~w_c_seg[7];
               end
            end
         end
         if (w_clr_err)    r_sh_err <= w_bad;
         else if (w_store) r_sh_err <= r_sh_err | w_bad;
         if (w_load) begin
            r_data <= r_sh_data;
            r_dp   <= r_sh_dp;
            r_err  <= r_sh_err;
         end
      end
   end

   assign data_out   = r_data;
   assign dp_out     = r_dp;
   assign code_err   = r_err;
   assign data_valid = r_dv;
   assign seq_err    = r_seq;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Scoreboard bench for seg_scan_decoder: frames are queued as they are scanned and
// compared when data_valid fires; sequence/timeout/reset behaviour checked per task.
module tb_seg_scan_decoder;

   localparam int unsigned S = 4;
   localparam int unsigned T = 64;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  sel;
   logic [7:0]  seg;
   logic [23:0] data_out;
   logic [5:0]  dp_out;
   logic        data_valid, code_err, seq_err;

   always #10 clk = ~clk;

   seg_scan_decoder #(.SETTLE_CYC(S), .TIMEOUT_CYC(T)) dut (
      .clk(clk), .rst(rst), .sel(sel), .seg(seg),
      .data_out(data_out), .dp_out(dp_out), .data_valid(data_valid),
      .code_err(code_err), .seq_err(seq_err)
   );

   typedef struct {
      logic [23:0] d;
      logic [5:0]  dp;
      logic        err;
   } frame_t;

   frame_t sb[$];
   logic [6:0] seg7 [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
   int n_vec = 0, n_err = 0;
   int dv_cnt = 0, seq_cnt = 0, cyc = 0, dv_cyc = 0, d5_cyc = 0;

   always @(posedge clk) cyc = cyc + 1;

   always @(negedge clk) begin
      frame_t e;
      if (seq_err === 1'b1) seq_cnt = seq_cnt + 1;
      if (data_valid === 1'b1) begin
         dv_cnt = dv_cnt + 1;
         dv_cyc = cyc;
         n_vec  = n_vec + 1;
         if (sb.size() == 0) begin
            n_err = n_err + 1;
            $display("FAIL unexpected_valid: data_out=%h dp=%b err=%b, no frame expected", data_out, dp_out, code_err);
         end else begin
            e = sb.pop_front();
            if ({data_out, dp_out, code_err} !== {e.d, e.dp, e.err}) begin
               n_err = n_err + 1;
               $display("FAIL frame: got data=%h dp=%b err=%b, want data=%h dp=%b err=%b",
                        data_out, dp_out, code_err, e.d, e.dp, e.err);
            end
         end
      end
   end

   task automatic hold(input logic [2:0] s, input logic [7:0] g, input int n);
      sel = s;
      seg = g;
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Scan digits 0..last; digit `bad` gets the blank pattern, digit `gl` gets a 2-cycle glitch.
   task automatic scan(input logic [23:0] d, input logic [5:0] dp, input int bad,
                       input int gl, input int last, input bit push);
      frame_t     e;
      logic [3:0] nib;
      logic [7:0] g;
      e.d = d; e.dp = dp; e.err = 1'b0;
      for (int k = 0; k <= last; k++) begin
         nib = d[(5-k)*4 +: 4];
         g   = {~dp[5-k], seg7[nib]};
         if (k == bad) begin
            g[6:0] = 7'h7F;
            e.d[(5-k)*4 +: 4] = 4'h0;
            e.err = 1'b1;
         end
         if (k == 5 && push) begin
            sb.push_back(e);
            d5_cyc = cyc;
         end
         if (k == gl) begin
            hold(3'(k), g, 3);
            hold(3'(k), ~g, 2);
            hold(3'(k), g, 8);
         end else begin
            hold(3'(k), g, 8);
         end
      end
      hold(3'd7, 8'hFF, 8);
   endtask

   task automatic expect_counts(input string name, input int dv0, input int sq0,
                                input int dv_exp, input int sq_exp);
      n_vec = n_vec + 1;
      if ((dv_cnt - dv0) !== dv_exp || (seq_cnt - sq0) !== sq_exp) begin
         n_err = n_err + 1;
         $display("FAIL %s: valid pulses=%0d seq_err pulses=%0d, want %0d and %0d",
                  name, dv_cnt - dv0, seq_cnt - sq0, dv_exp, sq_exp);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; sel = 3'd7; seg = 8'hFF;
      repeat (3) @(posedge clk);
      #1;
      n_vec = n_vec + 1;
      if ({data_out, dp_out, data_valid, code_err, seq_err} !== 33'd0) begin
         n_err = n_err + 1;
         $display("FAIL reset_outputs: got %h/%b/%b/%b/%b, want all 0", data_out, dp_out, data_valid, code_err, seq_err);
      end
      rst = 1'b0;
      hold(3'd7, 8'hFF, 10);
   endtask

   task automatic test_basic;
      int dv0 = dv_cnt, sq0 = seq_cnt;
      scan(24'h190905, 6'b000000, -1, -1, 5, 1'b1);
      n_vec = n_vec + 1;
      if ((dv_cyc - d5_cyc) !== int'(S + 3)) begin
         n_err = n_err + 1;
         $display("FAIL latency: got %0d cycles, want %0d", dv_cyc - d5_cyc, S + 3);
      end
      scan(24'h190905, 6'b000000, -1, -1, 5, 1'b1);
      expect_counts("basic_counts", dv0, sq0, 2, 0);
   endtask

   task automatic test_dp;
      int dv0 = dv_cnt, sq0 = seq_cnt;
      scan(24'hABCDEF, 6'b001000, -1, -1, 5, 1'b1);
      expect_counts("dp_counts", dv0, sq0, 1, 0);
   endtask

   task automatic test_order;
      int dv0 = dv_cnt, sq0 = seq_cnt;
      hold(3'd0, {1'b1, seg7[1]}, 8);
      hold(3'd1, {1'b1, seg7[2]}, 8);
      hold(3'd3, {1'b1, seg7[4]}, 8);
      expect_counts("order_seq_err", dv0, sq0, 0, 1);
      hold(3'd7, 8'hFF, 8);
      scan(24'h123456, 6'b000000, -1, -1, 5, 1'b1);
      expect_counts("order_recover", dv0, sq0, 1, 1);
   endtask

   task automatic test_code_err;
      int dv0 = dv_cnt, sq0 = seq_cnt;
      scan(24'h190905, 6'b000000, 1, -1, 5, 1'b1);
      scan(24'h190905, 6'b000000, -1, -1, 5, 1'b1);
      expect_counts("code_err_counts", dv0, sq0, 2, 0);
   endtask

   task automatic test_timeout;
      int dv0 = dv_cnt, sq0 = seq_cnt;
      scan(24'h654321, 6'b111111, -1, -1, 2, 1'b0);
      hold(3'd7, 8'hFF, 100);
      expect_counts("timeout_counts", dv0, sq0, 0, 1);
      n_vec = n_vec + 1;
      if ({data_out, dp_out, code_err} !== {24'h190905, 6'b000000, 1'b0}) begin
         n_err = n_err + 1;
         $display("FAIL timeout_hold: got data=%h dp=%b err=%b, want 190905/000000/0", data_out, dp_out, code_err);
      end
   endtask

   task automatic test_glitch;
      int dv0 = dv_cnt, sq0 = seq_cnt;
      scan(24'h2468AC, 6'b100001, -1, 2, 5, 1'b1);
      expect_counts("glitch_counts", dv0, sq0, 1, 0);
   endtask

   task automatic test_rst_midframe;
      int dv0 = dv_cnt, sq0 = seq_cnt;
      scan(24'h777777, 6'b000000, -1, -1, 2, 1'b0);
      hold(3'd3, {1'b1, seg7[7]}, 2);
      rst = 1'b1;
      sel = 3'd7; seg = 8'hFF;
      #1;
      n_vec = n_vec + 1;
      if ({data_out, dp_out, data_valid, code_err, seq_err} !== 33'd0) begin
         n_err = n_err + 1;
         $display("FAIL rst_midframe: got %h/%b/%b/%b/%b, want all 0", data_out, dp_out, data_valid, code_err, seq_err);
      end
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      hold(3'd7, 8'hFF, 20);
      expect_counts("rst_no_pulse", dv0, sq0, 0, 0);
      scan(24'hFEDCBA, 6'b000010, -1, -1, 5, 1'b1);
      expect_counts("rst_recover", dv0, sq0, 1, 0);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_dp();
      test_order();
      test_code_err();
      test_timeout();
      test_glitch();
      test_rst_midframe();
      hold(3'd7, 8'hFF, 10);
      n_vec = n_vec + 1;
      if (sb.size() !== 0) begin
         n_err = n_err + 1;
         $display("FAIL pending_frames: %0d frames never reported, want 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
